fib_stream_checker: RTL and testbench

- Parametrised, sequential Fibonacci-membership checker for CH channels of W-bit unsigned values.
- Accepts one CH-wide sample per valid/ready handshake and walks the Fibonacci sequence one term per clock.
- Produces a per-channel "is Fibonacci" flag plus a combined flag f; the combining rule is selected by MODE.
- Generalises the team's 3×4-bit combinational Fibonacci detector into a streaming block that sits between a producer and consumer with backpressure.

---
 rtl/fib_stream_checker_pkg.sv | 33 +++
 rtl/fib_stream_checker_if.sv | 21 ++
 rtl/fib_stream_checker_seq.sv | 33 +++
 rtl/fib_stream_checker.sv | 85 ++++++++
 tb/tb_fib_stream_checker.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fib_stream_checker_pkg.sv
// fib_pkg: shared types and helpers for the streaming Fibonacci-membership checker.
//   state_t     : controller states (IDLE -> SCAN -> DONE -> IDLE)
//   MODE_ALL/ANY: rules for combining the per-channel flags into f
//   max_of()    : largest of ch w-bit values packed little-end-first in a bus
package fib_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int MODE_ALL = 0;
  localparam int MODE_ANY = 1;

  // Widest configuration the max helper can handle; callers zero-extend into BUS_W.
  localparam int MAX_W  = 32;
  localparam int MAX_CH = 16;
  localparam int BUS_W  = MAX_W * MAX_CH;

  // Loops have constant bounds so the helper unrolls cleanly; ch/w gate the
  // live iterations and are constants at every call site.
  function automatic logic [MAX_W-1:0] max_of(input logic [BUS_W-1:0] data,
                                               input int ch, input int w);
    logic [MAX_W-1:0] m, v, mask;
    m    = '0;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < ch) begin
        v = MAX_W'(data >> (i * w)) & mask;
        if (v > m) m = v;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/fib_stream_checker_if.sv
// Stream interface for fib_stream_checker.
//   in_valid/in_ready/in_data  : sample handshake, channel i at in_data[W*i +: W]
//   out_valid/out_ready        : result handshake
//   out_flags/f                : per-channel Fibonacci flags and combined flag
//   busy                       : checker is walking the sequence
// master = producer/consumer side, slave = checker side.
interface fib_stream_checker_if #(parameter int W = 4, parameter int CH = 3);
  logic            in_valid;
  logic            in_ready;
  logic [CH*W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH-1:0]   out_flags;
  logic            f;
  logic            busy;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_flags, f, busy);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_flags, f, busy);
endinterface

// File: rtl/fib_stream_checker_seq.sv
// fib_seq: Fibonacci term generator, one step per adv.
//   clk, rst : clock, async active-high reset (terms cleared to 0)
//   load     : restart at (fa, fb) = (F0, F1) = (0, 1)
//   adv      : step (fa, fb) <- (fb, fa + fb)
//   fa, fb   : current and next term, W+1 bits
// fb may wrap on the final step past the caller's bound; only fa is compared
// after that, and fa is always the previous fb, which never wraps.
module fib_seq #(parameter int W = 4) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [W:0] fa,
  output logic [W:0] fb
);
  logic [W:0] fa_q, fb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_q <= '0;
      fb_q <= '0;
    end else if (load) begin
      fa_q <= '0;
      fb_q <= (W+1)'(1);
    end else if (adv) begin
      fa_q <= fb_q;
      fb_q <= fa_q + fb_q;
    end
  end

  assign fa = fa_q;
  assign fb = fb_q;
endmodule

// File: rtl/fib_stream_checker.sv
// fib_stream_checker: streaming Fibonacci-membership checker for CH channels of
// W-bit unsigned values. A sample is captured in IDLE, the sequence is walked one
// term per clock in SCAN until the term exceeds the channel maximum, and the
// sticky flags are presented in DONE until the consumer takes them.
//   clk, rst : clock, async active-high reset
//   bus_if   : slave side of fib_stream_checker_if (handshakes, flags, f, busy)
// MODE selects f: MODE_ALL = AND of flags, MODE_ANY = OR of flags.
module fib_stream_checker import fib_pkg::*; #(
  parameter int W    = 4,
  parameter int CH   = 3,
  parameter int MODE = MODE_ALL
) (
  input  logic                  clk,
  input  logic                  rst,
  fib_stream_checker_if.slave   bus_if
);
  state_t               state_q, state_d;
  logic [CH-1:0][W-1:0] val_q;
  logic [W-1:0]         maxv_q, maxv_d;
  logic [CH-1:0]        flags_q, flags_d;
  logic                 load, adv, capture;
  logic [W:0]           fa;
  logic [W:0]           unused_fb;

  fib_seq #(.W(W)) u_seq (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .adv  (adv),
    .fa   (fa),
    .fb   (unused_fb)
  );

  assign maxv_d = W'(max_of(BUS_W'(bus_if.in_data), CH, W));

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    load    = 1'b0;
    adv     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (bus_if.in_valid) begin
        capture = 1'b1;
        load    = 1'b1;
        flags_d = '0;
        state_d = SCAN;
      end
      SCAN: begin
        // Exit cycle does no compare and leaves the generator untouched.
        if (fa > {1'b0, maxv_q}) begin
          state_d = DONE;
        end else begin
          for (int i = 0; i < CH; i++)
            if ({1'b0, val_q[i]} == fa) flags_d[i] = 1'b1;
          adv = 1'b1;
        end
      end
      DONE: if (bus_if.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      maxv_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (capture) begin
        val_q  <= bus_if.in_data;
        maxv_q <= maxv_d;
      end
    end
  end

  assign bus_if.in_ready  = (state_q == IDLE);
  assign bus_if.out_valid = (state_q == DONE);
  assign bus_if.busy      = (state_q == SCAN);
  assign bus_if.out_flags = flags_q;
  assign bus_if.f         = (MODE == MODE_ANY) ? |flags_q : &flags_q;
endmodule

// File: tb/tb_fib_stream_checker.sv
// Bench for fib_stream_checker: three instances (W4/CH3 ALL, W4/CH3 ANY sharing
// one stimulus, W8/CH4 ALL), directed cases then random samples against an
// arithmetic Fibonacci model.
`timescale 1ns/1ps
module tb_fib_stream_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_stream_checker_if #(.W(4), .CH(3)) if0 ();
  fib_stream_checker_if #(.W(4), .CH(3)) if1 ();
  fib_stream_checker_if #(.W(8), .CH(4)) if2 ();

  logic        v4, r4, v8, r8;
  logic [11:0] d4;
  logic [31:0] d8;
  assign if0.in_valid = v4; assign if0.in_data = d4; assign if0.out_ready = r4;
  assign if1.in_valid = v4; assign if1.in_data = d4; assign if1.out_ready = r4;
  assign if2.in_valid = v8; assign if2.in_data = d8; assign if2.out_ready = r8;

  fib_stream_checker #(.W(4), .CH(3), .MODE(0)) d0 (.clk(clk), .rst(rst), .bus_if(if0));
  fib_stream_checker #(.W(4), .CH(3), .MODE(1)) d1 (.clk(clk), .rst(rst), .bus_if(if1));
  fib_stream_checker #(.W(8), .CH(4), .MODE(0)) d2 (.clk(clk), .rst(rst), .bus_if(if2));

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on the Fibonacci sequence ----
  function automatic bit is_fib(input int v);
    int a = 0, b = 1, t;
    while (a < v) begin t = a + b; a = b; b = t; end
    return a == v;
  endfunction

  // number of indices k with F_k <= m (1 counted twice)
  function automatic int kcount(input int m);
    int a = 0, b = 1, t, k = 0;
    while (a <= m) begin k++; t = a + b; a = b; b = t; end
    return k;
  endfunction

  function automatic int chan(input logic [31:0] d, input int i, input int w);
    return int'((d >> (i * w)) & ((32'd1 << w) - 1));
  endfunction

  function automatic int ref_max(input logic [31:0] d, input int ch, input int w);
    int m = 0;
    for (int i = 0; i < ch; i++) if (chan(d, i, w) > m) m = chan(d, i, w);
    return m;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [31:0] d, input int ch, input int w);
    logic [3:0] fl = '0;
    for (int i = 0; i < ch; i++) fl[i] = is_fib(chan(d, i, w));
    return fl;
  endfunction

  // ---- DUT observation helpers (s=0: 4-bit pair, s=1: 8-bit) ----
  function automatic logic rdy(input int s); return s != 0 ? if2.in_ready  : if0.in_ready;  endfunction
  function automatic logic ov (input int s); return s != 0 ? if2.out_valid : if0.out_valid; endfunction

  task automatic send(input int s, input logic [31:0] d);
    int n = 0;
    while (!rdy(s) && n < 200) begin @(posedge clk); #1; n++; end
    chk("send_ready", 32'(rdy(s)), 32'd1);
    if (s != 0) begin v8 = 1'b1; d8 = d; end
    else begin v4 = 1'b1; d4 = d[11:0]; end
    @(posedge clk); #1;
    v4 = 1'b0; v8 = 1'b0;
  endtask

  task automatic wait_done(input int s, input logic [31:0] d, input string tag, output int lat);
    int n = 0;
    int ch = (s != 0) ? 4 : 3;
    int w  = (s != 0) ? 8 : 4;
    logic [3:0] fl;
    while (!ov(s) && n < 200) begin @(posedge clk); #1; n++; end
    lat = n;
    chk({tag, "_lat"}, 32'(n), 32'(kcount(ref_max(d, ch, w)) + 1));
    fl = ref_flags(d, ch, w);
    if (s != 0) begin
      chk({tag, "_flags8"}, 32'(if2.out_flags), 32'(fl));
      chk({tag, "_f8"}, 32'(if2.f), 32'(&fl));
    end else begin
      chk({tag, "_flags_all"}, 32'(if0.out_flags), 32'(fl[2:0]));
      chk({tag, "_f_all"}, 32'(if0.f), 32'(&fl[2:0]));
      chk({tag, "_flags_any"}, 32'(if1.out_flags), 32'(fl[2:0]));
      chk({tag, "_f_any"}, 32'(if1.f), 32'(|fl[2:0]));
    end
  endtask

  task automatic release_out(input int s);
    if (s != 0) r8 = 1'b1; else r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0; r8 = 1'b0;
    chk("in_ready_back", 32'(rdy(s)), 32'd1);
  endtask

  task automatic job(input int s, input logic [31:0] d, input string tag, output int lat);
    send(s, d);
    wait_done(s, d, tag, lat);
    release_out(s);
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    rst = 1'b1; v4 = 1'b0; r4 = 1'b0; v8 = 1'b0; r8 = 1'b0; d4 = '0; d8 = '0;
    #7;
    chk("rst_ov",    32'(if0.out_valid), 32'd0);
    chk("rst_busy",  32'(if0.busy), 32'd0);
    chk("rst_flags", 32'(if0.out_flags), 32'd0);
    chk("rst_f",     32'(if0.f), 32'd0);
    chk("rst_f_any", 32'(if1.f), 32'd0);
    chk("rst_ov8",   32'(if2.out_valid), 32'd0);
    #5 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_inrdy",  32'(if0.in_ready), 32'd1);
    chk("rst_inrdy8", 32'(if2.in_ready), 32'd1);

    // directed cases from the plan
    job(0, {20'd0, 4'd1, 4'd0, 4'd11}, "t11_0_1", lat);
    chk("t11_0_1_lat8", 32'(lat), 32'd8);
    chk("t11_0_1_flags", 32'(if0.out_flags), 32'b110);
    chk("t11_0_1_f", 32'(if0.f), 32'd0);
    job(0, {20'd0, 4'd1, 4'd5, 4'd13}, "t13_5_1", lat);
    chk("t13_5_1_lat9", 32'(lat), 32'd9);
    chk("t13_5_1_flags", 32'(if0.out_flags), 32'b111);
    chk("t13_5_1_f", 32'(if0.f), 32'd1);
    job(0, {20'd0, 4'd6, 4'd6, 4'd6}, "t6_6_6", lat);
    chk("t6_6_6_flags", 32'(if0.out_flags), 32'b000);
    chk("t6_6_6_f", 32'(if0.f), 32'd0);
    job(0, {20'd0, 4'd1, 4'd5, 4'd15}, "t15_5_1", lat);
    chk("t15_5_1_flags_any", 32'(if1.out_flags), 32'b110);
    chk("t15_5_1_f_any", 32'(if1.f), 32'd1);
    job(1, {8'd0, 8'd255, 8'd144, 8'd233}, "w8", lat);
    chk("w8_lat15", 32'(lat), 32'd15);
    chk("w8_flags", 32'(if2.out_flags), 32'b1011);
    chk("w8_f", 32'(if2.f), 32'd0);

    // backpressure: result held, new sample waits
    send(0, {20'd0, 4'd1, 4'd5, 4'd13});
    wait_done(0, {20'd0, 4'd1, 4'd5, 4'd13}, "bp1", lat);
    v4 = 1'b1; d4 = {4'd3, 4'd2, 4'd4};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_flags", 32'(if0.out_flags), 32'b111);
      chk("bp_f", 32'(if0.f), 32'd1);
      chk("bp_inrdy", 32'(if0.in_ready), 32'd0);
      chk("bp_ov", 32'(if0.out_valid), 32'd1);
    end
    r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
    chk("bp_idle_inrdy", 32'(if0.in_ready), 32'd1);
    chk("bp_idle_busy", 32'(if0.busy), 32'd0);
    @(posedge clk); #1;
    v4 = 1'b0;
    chk("bp_taken_busy", 32'(if0.busy), 32'd1);
    wait_done(0, {20'd0, 4'd3, 4'd2, 4'd4}, "bp2", lat);
    chk("bp2_flags", 32'(if0.out_flags), 32'b110);
    release_out(0);

    // asynchronous reset on the third SCAN cycle
    send(0, {20'd0, 4'd15, 4'd15, 4'd15});
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(if0.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(if0.busy), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_inrdy", 32'(if0.in_ready), 32'd1);
    chk("mid_rst_flags", 32'(if0.out_flags), 32'd0);
    job(0, {20'd0, 4'd8, 4'd7, 4'd2}, "post_rst", lat);
    chk("post_rst_flags", 32'(if0.out_flags), 32'b101);

    // random samples against the model
    for (int i = 0; i < 20; i++) begin
      rd = $urandom;
      job(0, {20'd0, rd[11:0]}, "rnd4", lat);
    end
    for (int i = 0; i < 12; i++) begin
      rd = $urandom;
      job(1, rd, "rnd8", lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
